alu_mdu: RTL

- Sequential execute unit for lx32 and the successor to the combinational ALU.
- Adds RV32M multiply/divide, implemented iteratively with radix-2 shift-add and non-restoring-free restoring division.
- Base ALU ops are registered, so every op shares one valid/ready handshake.
- Sits in EX; the pipeline stalls on in_ready=0 and takes results through the out handshake.

---
 rtl/alu_mdu.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: registered RV32I ALU plus iterative RV32M multiply/divide for lx32 EX (LX32_FAST_MUL_EN selects a one-shot multiplier).
// Latency: base ops, div-by-zero, signed overflow and illegal ops take 1 cycle; mul/div take WIDTH+2 (fast mul: 2).
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready; flush aborts from any state.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int SH_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mcand;
    logic               neg, take_hi, is_div;

    logic               is_mul_op, is_div_op, quick;
    logic               a_signed, b_signed, a_neg, b_neg;
    logic               div_zero, div_ovf, neg_ld;
    logic [WIDTH-1:0]   mag_a, mag_b, quick_res;
    logic [2*WIDTH-1:0] prod_ld;
    logic [SH_W-1:0]    shamt;

    assign is_mul_op = (op[4:2] == 3'b100);
    assign is_div_op = (op[4:2] == 3'b101);
    assign a_signed  = (op == 5'd17) || (op == 5'd18) || (op == 5'd20) || (op == 5'd22);
    assign b_signed  = (op == 5'd17) || (op == 5'd20) || (op == 5'd22);
    assign a_neg     = a_signed && src_a[WIDTH-1];
    assign b_neg     = b_signed && src_b[WIDTH-1];
    assign mag_a     = a_neg ? -src_a : src_a;
    assign mag_b     = b_neg ? -src_b : src_b;
    assign div_zero  = (src_b == '0);
    assign div_ovf   = a_signed && (src_a == {1'b1, {(WIDTH-1){1'b0}}}) && (src_b == '1);
    assign quick     = !(is_mul_op || is_div_op) || (is_div_op && (div_zero || div_ovf));
    assign shamt     = src_b[SH_W-1:0];

    always_comb begin
        quick_res = '0;
        case (op)
            5'd0: quick_res = src_a + src_b;
            5'd1: quick_res = src_a - src_b;
            5'd2: quick_res = src_a << shamt;
            5'd3: quick_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            5'd4: quick_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            5'd5: quick_res = src_a ^ src_b;
            5'd6: quick_res = src_a >> shamt;
            5'd7: quick_res = $signed(src_a) >>> shamt;
            5'd8: quick_res = src_a | src_b;
            5'd9: quick_res = src_a & src_b;
            default: begin
                // op[1] distinguishes REM/REMU from DIV/DIVU
                if (is_div_op) begin
                    if (div_zero) quick_res = op[1] ? src_a : '1;
                    else          quick_res = op[1] ? '0 : src_a;
                end
            end
        endcase
    end

`ifdef LX32_FAST_MUL_EN
    logic [2*WIDTH-1:0] a_sx, b_sx, fast_prod;
    assign a_sx      = {{WIDTH{a_neg}}, src_a};
    assign b_sx      = {{WIDTH{b_neg}}, src_b};
    assign fast_prod = a_sx * b_sx;
`endif

    always_comb begin
        prod_ld = is_div_op ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
        neg_ld  = (is_div_op && op[1]) ? a_neg : (a_neg ^ b_neg);
`ifdef LX32_FAST_MUL_EN
        // the full signed product needs no sign fix-up
        if (is_mul_op) begin
            prod_ld = fast_prod;
            neg_ld  = 1'b0;
        end
`endif
    end

    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] mul_step, div_step, prod_fix;
    logic [WIDTH-1:0]   half, fix_res;

    assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    assign mul_step  = {mul_sum, prod[WIDTH-1:1]};
    assign div_trial = prod[2*WIDTH-1:WIDTH-1] - {1'b0, mcand};
    assign div_step  = div_trial[WIDTH] ? {prod[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};

    // Products are negated across all 2*WIDTH bits; quotient/remainder per half.
    assign prod_fix = (neg && !is_div) ? -prod : prod;
    assign half     = take_hi ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
    assign fix_res  = (neg && is_div) ? -half : half;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (quick) state_nxt = DONE;
`ifdef LX32_FAST_MUL_EN
                    else       state_nxt = is_mul_op ? FIX : CALC;
`else
                    else       state_nxt = CALC;
`endif
                end
            end
            CALC:    if (cnt == CNT_W'(1)) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result  <= '0;
            cnt     <= '0;
            prod    <= '0;
            mcand   <= '0;
            neg     <= 1'b0;
            take_hi <= 1'b0;
            is_div  <= 1'b0;
        end else if (!flush) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (quick) begin
                            result <= quick_res;
                        end else begin
                            prod    <= prod_ld;
                            mcand   <= is_div_op ? mag_b : mag_a;
                            neg     <= neg_ld;
                            take_hi <= is_div_op ? op[1] : (op != 5'd16);
                            is_div  <= is_div_op;
                            cnt     <= CNT_W'(WIDTH);
                        end
                    end
                end
                CALC: begin
                    cnt  <= cnt - CNT_W'(1);
                    prod <= is_div ? div_step : mul_step;
                end
                FIX:     result <= fix_res;
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == CALC) || (state == FIX);

endmodule
